// File: rtl/instr_cache_dm.sv
// instr_cache_dm: direct-mapped read-only instruction cache with line refill FSM and flush.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module instr_cache_dm #(
   parameter int ADDR_W         = 32,
   parameter int NUM_LINES      = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_req,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic [31:0]       mem_rdata,
`ifdef ICACHE_PERF_CNT_EN
   input  logic              mem_ready,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`else
   input  logic              mem_ready
`endif
);
   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

   typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

   state_t               state_q, state_d;
   logic [OFF_W-1:0]     cnt_q, cnt_d;
   logic [TAG_W-1:0]     rtag_q, rtag_d;
   logic [IDX_W-1:0]     ridx_q, ridx_d;
   logic                 fpend_q, fpend_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

   logic [OFF_W-1:0] c_off;
   logic [IDX_W-1:0] c_idx;
   logic [TAG_W-1:0] c_tag;
   logic             hit, last, wr, miss;
   logic             unused_ok;

   assign c_off     = cpu_addr[OFF_W+1:2];
   assign c_idx     = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
   assign c_tag     = cpu_addr[ADDR_W-1:IDX_W+OFF_W+2];
   assign hit       = valid_q[c_idx] && tag_q[c_idx] == c_tag;
   assign last      = cnt_q == OFF_W'(WORDS_PER_LINE-1);
   assign wr        = state_q == REFILL && mem_ready;
   assign unused_ok = ^cpu_addr[1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rtag_d    = rtag_q;
      ridx_d    = ridx_q;
      fpend_d   = fpend_q;
      valid_d   = flush ? '0 : valid_q;
      cpu_ready = 1'b0;
      cpu_rdata = data_q[c_idx][c_off];
      mem_req   = 1'b0;
      mem_addr  = '0;
      miss      = 1'b0;
      case (state_q)
         IDLE: begin
            cpu_ready = cpu_req && hit && !flush;
            if (cpu_req && !hit && !flush) begin
               state_d = REFILL;
               rtag_d  = c_tag;
               ridx_d  = c_idx;
               cnt_d   = '0;
               miss    = 1'b1;
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {rtag_q, ridx_q, cnt_q, 2'b00};
            fpend_d  = fpend_q || flush;
            if (mem_ready) begin
               cnt_d = cnt_q + 1'b1;
               if (last) begin
                  state_d = FILL_DONE;
                  // a flush seen at any point of this refill keeps the line invalid
                  if (!fpend_q && !flush) valid_d[ridx_q] = 1'b1;
               end
            end
         end
         FILL_DONE: begin
            state_d = IDLE;
            fpend_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rtag_q  <= '0;
         ridx_q  <= '0;
         fpend_q <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rtag_q  <= rtag_d;
         ridx_q  <= ridx_d;
         fpend_q <= fpend_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         data_q[ridx_q][cnt_q] <= mem_rdata;
         if (last) tag_q[ridx_q] <= rtag_q;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         hit_cnt  <= hit_cnt + 32'(cpu_req && cpu_ready);
         miss_cnt <= miss_cnt + 32'(miss);
      end
   end
`endif
endmodule

// File: tb/tb_instr_cache_dm.sv
// tb_instr_cache_dm: directed self-checking bench for instr_cache_dm with a latency-programmable memory.
module tb_instr_cache_dm;
   logic        clk = 1'b0;
   logic        rst_n, flush, cpu_req, cpu_ready, mem_req;
   logic        mem_ready = 1'b0;
   logic [31:0] cpu_addr, cpu_rdata, mem_addr, mem_rdata;
   logic [7:0]  gen;
   int          lat, wcnt = 0, words = 0;
   int          checks = 0, failures = 0;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   instr_cache_dm dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_req(mem_req),
`ifdef ICACHE_PERF_CNT_EN
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`else
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`endif
   );

   always #5 clk = ~clk;

   assign mem_rdata = {gen, 8'hDE, mem_addr[15:0]};

   // memory answers each word on the lat-th cycle it has been requested
   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ready = 1'b0;
         wcnt = 0;
      end else if (wcnt + 1 >= lat) begin
         mem_ready = 1'b1;
         wcnt = 0;
      end else begin
         mem_ready = 1'b0;
         wcnt++;
      end
   end

   always @(posedge clk) if (mem_req && mem_ready) words <= words + 1;

   task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tg, got, exp);
      end
   endtask

   // starts just after a rising edge; n counts cycles from request to cpu_ready
   task automatic fetch(input string tg, input logic [31:0] a, input int lt, input int fl_at,
                        input int exp_n, input logic [31:0] exp_d);
      int n;
      int w0;
      logic rdy;
      lat = lt;
      cpu_addr = a;
      cpu_req = 1'b1;
      w0 = words;
      rdy = 1'b0;
      for (n = 0; n < 60; n++) begin
         flush = (n == fl_at);
         @(negedge clk); #1;
         if (mem_req) chk({tg, "_maddr"}, mem_addr, {a[31:4], 4'h0} + 32'(((words - w0) % 4) * 4));
         if (cpu_ready) begin
            rdy = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk({tg, "_lat"}, 32'(n), 32'(exp_n));
      if (rdy) chk({tg, "_data"}, cpu_rdata, exp_d);
      if (exp_n == 0) chk({tg, "_memreq"}, {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      cpu_req = 1'b0;
      cpu_addr = '0;
      lat = 1;
      gen = 8'h11;
      #1;
      chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_memreq", {31'd0, mem_req}, 32'd0);
      chk("rst_maddr", mem_addr, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
      chk("rst_hitcnt", hit_cnt, 32'd0);
      chk("rst_misscnt", miss_cnt, 32'd0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      fetch("cold", 32'h104, 1, -1, 6, 32'h11DE0104);
      fetch("hit_last", 32'h10C, 1, -1, 0, 32'h11DE010C);
      fetch("hit_first", 32'h100, 1, -1, 0, 32'h11DE0100);
      gen = 8'h22;
      fetch("conflict", 32'h504, 1, -1, 6, 32'h22DE0504);
      fetch("hit_conf", 32'h508, 1, -1, 0, 32'h22DE0508);
      fetch("remiss", 32'h104, 1, -1, 6, 32'h22DE0104);
      gen = 8'h33;
      fetch("slow", 32'h304, 3, -1, 14, 32'h33DE0304);
      fetch("hit_slow", 32'h30C, 1, -1, 0, 32'h33DE030C);

      cpu_addr = 32'h104;
      cpu_req = 1'b1;
      flush = 1'b1;
      @(negedge clk); #1;
      chk("flush_ready", {31'd0, cpu_ready}, 32'd0);
      chk("flush_memreq", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      flush = 1'b0;
      gen = 8'h44;
      fetch("post_flush", 32'h104, 1, -1, 6, 32'h44DE0104);
      fetch("flush_other", 32'h30C, 1, -1, 6, 32'h44DE030C);
      fetch("flush_mid", 32'h408, 1, 2, 12, 32'h44DE0408);
      fetch("hit_mid", 32'h400, 1, -1, 0, 32'h44DE0400);

      cpu_addr = 32'h200;
      cpu_req = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_maddr", mem_addr, 32'h208);
      rst_n = 1'b0;
      #1;
      chk("midrst_memreq", {31'd0, mem_req}, 32'd0);
      chk("midrst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("midrst_maddr", mem_addr, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
      chk("midrst_hitcnt", hit_cnt, 32'd0);
      chk("midrst_misscnt", miss_cnt, 32'd0);
`endif
      cpu_req = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      gen = 8'h55;
      fetch("rst_refill", 32'h200, 1, -1, 6, 32'h55DE0200);
      fetch("rst_miss104", 32'h104, 1, -1, 6, 32'h55DE0104);
`ifdef ICACHE_PERF_CNT_EN
      chk("end_hitcnt", hit_cnt, 32'd2);
      chk("end_misscnt", miss_cnt, 32'd2);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
